// File: rtl/adc_avg_hold.sv
// adc_avg_hold: averages 2^LOG2_N valid ADC samples and publishes the mean on a
// 16-bit bus for the 7-segment decoder, then ignores samples for HOLD_CYCLES
// clocks so the display does not flicker.
// Ports: clk, reset_n (sync, active-low), sample_in/sample_valid (ADC strobe),
//   freeze (suppress publish), out/out_valid (registered mean + one-cycle pulse),
//   busy (LATCH or HOLD: samples discarded).
// Optional: define ADC_AVG_HOLD_PEAK_EN to add peak_clr input and peak output
//   (running maximum of all averages, independent of freeze).
module adc_avg_hold #(
  parameter int ADC_W       = 12,
  parameter int LOG2_N      = 4,
  parameter int HOLD_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADC_W-1:0]  sample_in,
  input  logic              sample_valid,
  input  logic              freeze,
`ifdef ADC_AVG_HOLD_PEAK_EN
  input  logic              peak_clr,
  output logic [15:0]       peak,
`endif
  output logic [15:0]       out,
  output logic              out_valid,
  output logic              busy
);

  // Accumulator is wide enough for N full-scale samples, so it cannot overflow.
  localparam int AW = ADC_W + LOG2_N;

  // Timer only has to hold HOLD_CYCLES-1; keep at least one bit so the
  // HOLD_CYCLES=0 build still elaborates (the HOLD state is unreachable then).
  localparam int TW        = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_LOAD);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    LATCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    acc;
  logic [LOG2_N-1:0] cnt;
  logic [TW-1:0]    timer;
  logic [AW-1:0]    acc_shift;
  logic [15:0]      avg;
  logic [15:0]      avg_q;
  logic             pub_q;
  logic             last_sample;

  // The N-th sample is accepted when the counter is all ones.
  assign last_sample = (state == ACCUM) && sample_valid && (cnt == '1);

  // Truncating mean; upper bits of the shifted accumulator are always zero.
  assign acc_shift = acc >> LOG2_N;
  assign avg       = 16'(acc_shift);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: begin
        if (last_sample) begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        state_nxt = (HOLD_CYCLES > 0) ? HOLD : ACCUM;
      end
      HOLD: begin
        if (timer == '0) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulator and sample counter. Samples are only taken in ACCUM, so a
  // strobe during LATCH or HOLD is dropped and every average starts empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (sample_valid) begin
            acc <= acc + {{LOG2_N{1'b0}}, sample_in};
            cnt <= cnt + 1'b1;
          end
        end
        LATCH: begin
          acc <= '0;
          cnt <= '0;
        end
        default: begin
          acc <= acc;
          cnt <= cnt;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Hold timer: loaded on LATCH, counts down to zero through HOLD, which
  // therefore lasts exactly HOLD_CYCLES clocks.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (state == LATCH) begin
      timer <= TIMER_LOAD;
    end else if ((state == HOLD) && (timer != '0)) begin
      timer <= timer - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Publish pipeline. The mean and the freeze decision are captured on the
  // LATCH edge and applied to out one edge later, which places the out_valid
  // pulse on the second edge after the N-th sample was accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      avg_q <= '0;
      pub_q <= 1'b0;
    end else begin
      pub_q <= (state == LATCH) && !freeze;
      if (state == LATCH) begin
        avg_q <= avg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (pub_q) begin
        out <= avg_q;
      end
      out_valid <= pub_q;
      // Registered from the next state so busy lines up with LATCH/HOLD.
      busy      <= (state_nxt != ACCUM);
    end
  end

`ifdef ADC_AVG_HOLD_PEAK_EN
  // ---------------------------------------------------------------------------
  // Peak tracker. A clear coinciding with LATCH takes the new mean directly
  // (clear first, then compare against zero).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      peak <= '0;
    end else if (state == LATCH) begin
      if (peak_clr || (avg > peak)) begin
        peak <= avg;
      end
    end else if (peak_clr) begin
      peak <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_adc_avg_hold.sv
// tb_adc_avg_hold: directed self-checking bench for adc_avg_hold with
// LOG2_N=2, HOLD_CYCLES=4, ADC_W=12. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_adc_avg_hold;

  localparam int ADC_W       = 12;
  localparam int LOG2_N      = 2;
  localparam int HOLD_CYCLES = 4;

  logic              clk;
  logic              reset_n;
  logic [ADC_W-1:0]  sample_in;
  logic              sample_valid;
  logic              freeze;
  logic [15:0]       out;
  logic              out_valid;
  logic              busy;
`ifdef ADC_AVG_HOLD_PEAK_EN
  logic              peak_clr;
  logic [15:0]       peak;
`endif

  int total;
  int bad;

  adc_avg_hold #(
    .ADC_W       (ADC_W),
    .LOG2_N      (LOG2_N),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .freeze       (freeze),
`ifdef ADC_AVG_HOLD_PEAK_EN
    .peak_clr     (peak_clr),
    .peak         (peak),
`endif
    .out          (out),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Four back-to-back samples; returns on the falling edge just after the
  // edge that accepted the 4th one, with sample_valid already dropped.
  task automatic send4(input int a, input int b, input int c, input int d);
    int v[4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = v[i][ADC_W-1:0];
    end
    @(negedge clk);
    sample_valid = 1'b0;
    sample_in    = '0;
  endtask

  // Observes 10 falling edges starting with the current one (index 0 = the
  // LATCH cycle). Optionally strobes 4000 whenever busy is seen high.
  task automatic collect(input bit strobe, output int pulses, output int first_idx,
                         output int busy_cnt);
    pulses    = 0;
    first_idx = -1;
    busy_cnt  = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (out_valid) begin
        pulses++;
        if (first_idx < 0) first_idx = k;
      end
      if (busy) busy_cnt++;
      if (strobe && busy) begin
        sample_valid = 1'b1;
        sample_in    = 12'd4000;
      end else begin
        sample_valid = 1'b0;
        sample_in    = '0;
      end
    end
    sample_valid = 1'b0;
  endtask

  int p, idx, bc;

  initial begin
    total        = 0;
    bad          = 0;
    reset_n      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    freeze       = 1'b0;
`ifdef ADC_AVG_HOLD_PEAK_EN
    peak_clr     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef ADC_AVG_HOLD_PEAK_EN
    chk("rst_peak", 32'(peak), 32'd0);
`endif
    reset_n = 1'b1;

    // Basic mean, latency and busy window.
    send4(100, 200, 300, 400);
    chk("t1_latch_no_pulse", 32'(out_valid), 32'd0);
    chk("t1_latch_busy", 32'(busy), 32'd1);
    collect(1'b0, p, idx, bc);
    chk("t1_pulses", 32'(p), 32'd1);
    chk("t1_pulse_idx", 32'(idx), 32'd2);
    chk("t1_busy_cycles", 32'(bc), 32'd5);
    chk("t1_out", 32'(out), 32'd250);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Full scale, no overflow.
    send4(4095, 4095, 4095, 4095);
    collect(1'b0, p, idx, bc);
    chk("t2_pulses", 32'(p), 32'd1);
    chk("t2_out", 32'(out), 32'h0FFF);

    // Truncation: 5/4 -> 1.
    send4(1, 1, 1, 2);
    collect(1'b0, p, idx, bc);
    chk("t3_pulses", 32'(p), 32'd1);
    chk("t3_out", 32'(out), 32'd1);

    // Strobes during LATCH/HOLD must be dropped.
    send4(0, 0, 0, 0);
    collect(1'b1, p, idx, bc);
    chk("t4_pulses", 32'(p), 32'd1);
    chk("t4_busy_cycles", 32'(bc), 32'd5);
    chk("t4_out", 32'(out), 32'd0);
    send4(30, 30, 30, 30);
    collect(1'b0, p, idx, bc);
    chk("t4b_out", 32'(out), 32'd30);

    // Freeze across a LATCH: no update, no pulse.
    freeze = 1'b1;
    send4(10, 10, 10, 10);
    collect(1'b0, p, idx, bc);
    chk("t5_frz_pulses", 32'(p), 32'd0);
    chk("t5_frz_busy", 32'(bc), 32'd5);
    chk("t5_frz_out", 32'(out), 32'd30);
    freeze = 1'b0;
    send4(20, 20, 20, 20);
    collect(1'b0, p, idx, bc);
    chk("t5_pulses", 32'(p), 32'd1);
    chk("t5_out", 32'(out), 32'd20);

    // Reset mid-accumulation discards partial sums.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in    = 12'd500;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    reset_n      = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t6_rst_out", 32'(out), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    send4(8, 8, 8, 8);
    collect(1'b0, p, idx, bc);
    chk("t6_pulses", 32'(p), 32'd1);
    chk("t6_pulse_idx", 32'(idx), 32'd2);
    chk("t6_out", 32'(out), 32'd8);

`ifdef ADC_AVG_HOLD_PEAK_EN
    send4(300, 300, 300, 300);
    collect(1'b0, p, idx, bc);
    send4(100, 100, 100, 100);
    collect(1'b0, p, idx, bc);
    chk("pk_out", 32'(out), 32'd100);
    chk("pk_max", 32'(peak), 32'd300);
    @(negedge clk);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    chk("pk_clr", 32'(peak), 32'd0);
    send4(50, 50, 50, 50);
    collect(1'b0, p, idx, bc);
    chk("pk_after_clr", 32'(peak), 32'd50);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
